// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order prediction queue pairing each prediction with its resolved outcome for predictor training.
module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int IP_WIDTH = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       pred_valid_i,
  input  logic [IP_WIDTH-1:0]        pred_ip_i,
  input  logic                       pred_taken_i,
  output logic                       pred_ready_o,
  input  logic                       res_valid_i,
  input  logic                       res_taken_i,
  input  logic                       flush_i,
  output logic                       upd_valid_o,
  output logic [IP_WIDTH-1:0]        upd_ip_o,
  output logic                       upd_taken_o,
  output logic                       mispredict_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [CNT_WIDTH-1:0]       branch_count_o,
  output logic [CNT_WIDTH-1:0]       mispredict_count_o,
  output logic                       overflow_err_o,
  output logic                       underflow_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [IP_WIDTH-1:0]  ip_mem [DEPTH];
  logic [DEPTH-1:0]     pt_mem;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d, mispredict_q, mispredict_d;
  logic [IP_WIDTH-1:0]  upd_ip_q, upd_ip_d;
  logic [CNT_WIDTH-1:0] branch_count_q, branch_count_d, mispredict_count_q, mispredict_count_d;
  logic                 overflow_err_q, overflow_err_d, underflow_err_q, underflow_err_d;
  logic                 push, pop, miss, empty;
  assign empty        = count_q == '0;
  assign pred_ready_o = count_q != CW'(DEPTH);
  assign push         = pred_valid_i && pred_ready_o && !flush_i;
  assign pop          = res_valid_i && !empty && !flush_i;
  assign miss         = pt_mem[rd_ptr_q] != res_taken_i;
  always_comb begin
    wr_ptr_d           = flush_i ? '0 : push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d           = flush_i ? '0 : pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d            = flush_i ? '0 : (push && !pop) ? count_q + CW'(1) : (pop && !push) ? count_q - CW'(1) : count_q;
    upd_valid_d        = pop;
    upd_ip_d           = pop ? ip_mem[rd_ptr_q] : upd_ip_q;
    upd_taken_d        = pop ? res_taken_i : upd_taken_q;
    mispredict_d       = pop ? miss : mispredict_q;
    branch_count_d     = (pop && !(&branch_count_q)) ? branch_count_q + CNT_WIDTH'(1) : branch_count_q;
    mispredict_count_d = (pop && miss && !(&mispredict_count_q)) ? mispredict_count_q + CNT_WIDTH'(1) : mispredict_count_q;
    overflow_err_d     = overflow_err_q || (pred_valid_i && !pred_ready_o && !flush_i);
    underflow_err_d    = underflow_err_q || (res_valid_i && empty && !flush_i);
  end
  // Entry storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      ip_mem[wr_ptr_q] <= pred_ip_i;
      pt_mem[wr_ptr_q] <= pred_taken_i;
    end
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_q           <= '0;
      rd_ptr_q           <= '0;
      count_q            <= '0;
      upd_valid_q        <= 1'b0;
      upd_ip_q           <= '0;
      upd_taken_q        <= 1'b0;
      mispredict_q       <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
      overflow_err_q     <= 1'b0;
      underflow_err_q    <= 1'b0;
    end else begin
      wr_ptr_q           <= wr_ptr_d;
      rd_ptr_q           <= rd_ptr_d;
      count_q            <= count_d;
      upd_valid_q        <= upd_valid_d;
      upd_ip_q           <= upd_ip_d;
      upd_taken_q        <= upd_taken_d;
      mispredict_q       <= mispredict_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
      overflow_err_q     <= overflow_err_d;
      underflow_err_q    <= underflow_err_d;
    end
  end
  assign count_o            = count_q;
  assign upd_valid_o        = upd_valid_q;
  assign upd_ip_o           = upd_ip_q;
  assign upd_taken_o        = upd_taken_q;
  assign mispredict_o       = mispredict_q;
  assign branch_count_o     = branch_count_q;
  assign mispredict_count_o = mispredict_count_q;
  assign overflow_err_o     = overflow_err_q;
  assign underflow_err_o    = underflow_err_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed self-checking bench; narrow statistics counters make saturation reachable.
module tb_branch_resolve_queue;
  logic        clk = 1'b0, reset = 1'b1;
  logic        pred_valid = 1'b0, pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0, flush = 1'b0;
  logic [63:0] pred_ip = '0;
  logic        pred_ready, upd_valid, upd_taken, mispredict, overflow_err, underflow_err;
  logic [63:0] upd_ip;
  logic [3:0]  count, branch_count, mispredict_count;
  int          errors = 0, checks = 0, n_br = 0, n_mis = 0;
  branch_resolve_queue #(.DEPTH(8), .IP_WIDTH(64), .CNT_WIDTH(4)) dut (
    .clk_i(clk), .reset_i(reset), .pred_valid_i(pred_valid), .pred_ip_i(pred_ip),
    .pred_taken_i(pred_taken), .pred_ready_o(pred_ready), .res_valid_i(res_valid),
    .res_taken_i(res_taken), .flush_i(flush), .upd_valid_o(upd_valid), .upd_ip_o(upd_ip),
    .upd_taken_o(upd_taken), .mispredict_o(mispredict), .count_o(count),
    .branch_count_o(branch_count), .mispredict_count_o(mispredict_count),
    .overflow_err_o(overflow_err), .underflow_err_o(underflow_err)
  );
  always #5 clk = ~clk;
  function automatic int sat(input int n);
    return n > 15 ? 15 : n;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc(input logic pv, input logic [63:0] ip, input logic pt, input logic rv, input logic rt, input logic fl);
    pred_valid = pv; pred_ip = ip; pred_taken = pt; res_valid = rv; res_taken = rt; flush = fl;
    @(posedge clk); #1;
    pred_valid = 1'b0; res_valid = 1'b0; flush = 1'b0;
  endtask
  task automatic chk_upd(input string tag, input logic [63:0] ip, input logic mis);
    chk({tag, "_valid"}, upd_valid, 1);
    chk({tag, "_ip"}, upd_ip, ip);
    chk({tag, "_mis"}, mispredict, mis);
  endtask
  task automatic chk_stats(input string tag);
    chk({tag, "_bc"}, branch_count, sat(n_br));
    chk({tag, "_mc"}, mispredict_count, sat(n_mis));
  endtask
  initial begin
    #3;
    chk("rst_count", count, 0);
    chk("rst_ready", pred_ready, 1);
    chk("rst_upd", upd_valid, 0);
    chk("rst_flags", {overflow_err, underflow_err}, 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    cyc(1, 64'h100, 1, 0, 0, 0);
    cyc(1, 64'h200, 0, 0, 0, 0);
    cyc(1, 64'h300, 1, 0, 0, 0);
    chk("t1_count3", count, 3);
    cyc(0, 0, 0, 1, 1, 0); chk_upd("t1_u0", 64'h100, 0);
    chk("t1_taken", upd_taken, 1);
    cyc(0, 0, 0, 1, 1, 0); chk_upd("t1_u1", 64'h200, 1);
    cyc(0, 0, 0, 1, 1, 0); chk_upd("t1_u2", 64'h300, 0);
    n_br += 3; n_mis += 1;
    cyc(0, 0, 0, 0, 0, 0);
    chk("t1_pulse", upd_valid, 0);
    chk("t1_hold_ip", upd_ip, 64'h300);
    chk("t1_count0", count, 0);
    chk_stats("t1");
    // interleaved push of entry k with resolve of entry k-1 wraps the pointers twice
    for (int k = 0; k <= 20; k++) begin
      cyc(k < 20, 64'(4 * k), (k % 3) == 0, k > 0, k > 0 && ((k - 1) % 2) == 0, 0);
      if (k > 0) begin
        logic m;
        m = (((k - 1) % 3) == 0) != (((k - 1) % 2) == 0);
        n_br++; n_mis += int'(m);
        chk_upd($sformatf("wrap%0d", k - 1), 64'(4 * (k - 1)), m);
      end
    end
    chk("wrap_count", count, 0);
    chk("wrap_flags", {overflow_err, underflow_err}, 0);
    chk_stats("wrap_sat");
    cyc(1, 64'hA0, 0, 0, 0, 0);
    cyc(1, 64'hA1, 0, 0, 0, 0);
    cyc(1, 64'hA2, 0, 0, 0, 0);
    cyc(1, 64'hA3, 0, 1, 0, 0); n_br++;
    chk("sim3_count", count, 3);
    chk_upd("sim3", 64'hA0, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc(0, 0, 0, 1, 0, 0); n_br++;
      chk_upd($sformatf("drain%0d", i), 64'hA0 + 64'(i), 0);
    end
    cyc(1, 64'hB0, 1, 1, 1, 0);
    chk("sim0_underflow", underflow_err, 1);
    chk("sim0_count", count, 1);
    chk("sim0_upd", upd_valid, 0);
    chk_stats("sim0");
    for (int i = 0; i < 4; i++) cyc(1, 64'hC0 + 64'(i), 1, 0, 0, 0);
    chk("fl_pre", count, 5);
    cyc(1, 64'hD0, 0, 1, 0, 1);
    chk("fl_count", count, 0);
    chk("fl_upd", upd_valid, 0);
    chk("fl_ovf", overflow_err, 0);
    chk("fl_ready", pred_ready, 1);
    chk_stats("fl");
    for (int i = 0; i < 8; i++) begin
      cyc(1, 64'h1000 + 64'(i), 0, 0, 0, 0);
      chk($sformatf("full_ready%0d", i), pred_ready, i < 7);
    end
    chk("full_count", count, 8);
    cyc(1, 64'h1FFF, 0, 0, 0, 0);
    chk("ovf_flag", overflow_err, 1);
    chk("ovf_count", count, 8);
    cyc(0, 0, 0, 1, 1, 0); n_br++; n_mis++;
    chk_upd("ovf_head", 64'h1000, 1);
    chk("ovf_ready", pred_ready, 1);
    reset = 1'b1; #1; reset = 1'b0;
    n_br = 0; n_mis = 0;
    chk("rst2_flags", {overflow_err, underflow_err}, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 64'h40 + 64'(i), i < 2, 0, 0, 0);
      cyc(0, 0, 0, 1, 0, 0); n_br++; n_mis += int'(i < 2);
    end
    for (int i = 0; i < 4; i++) cyc(1, 64'h80 + 64'(i), 0, 0, 0, 0);
    chk("mid_pre_count", count, 4);
    chk_stats("mid_pre");
    #2 reset = 1'b1; #1;
    chk("mid_count", count, 0);
    chk("mid_ready", pred_ready, 1);
    chk("mid_stats", {branch_count, mispredict_count}, 0);
    chk("mid_upd", {upd_valid, upd_ip, upd_taken, mispredict}, 0);
    chk("mid_flags", {overflow_err, underflow_err}, 0);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    cyc(0, 0, 0, 1, 1, 0);
    chk("post_underflow", underflow_err, 1);
    chk("post_upd", upd_valid, 0);
    chk("post_bc", branch_count, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
